// File: rtl/rc4_ctrl_fsm.sv
// RC4 sequencer: owns the I/J counters, steps the datapath through INIT, KSA and per-byte PRGA,
// and hands out len_i keystream bytes, one per ks_req_i.
//
// state   | meaning
// IDLE    | waiting for start_i
// CLEAR   | clear I and J before the schedule
// INIT    | S[I] = I for I = 0..SARR_DEPTH-1
// K_DETJ  | KSA: J <= next J from datapath
// K_SWAP  | KSA: swap S[I], S[J]; advance I
// READY   | waiting for ks_req_i
// P_INC   | PRGA: I <= I+1
// P_DETJ  | PRGA: J <= next J from datapath
// P_SWAP  | PRGA: swap S[I], S[J]
// P_TEMP  | PRGA: store S[I]+S[J]
// P_GEN   | PRGA: capture keystream byte
// P_OUT   | PRGA: present keystream byte
module rc4_ctrl_fsm #(
   parameter int SARR_DEPTH = 256,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             ks_req_i,
   input  logic [7:0]       ncounterJ_i,
   input  logic [7:0]       rdata_i,
   output logic [7:0]       counterI_o,
   output logic [7:0]       counterJ_o,
   output logic             clearCounterJ_o,
   output logic             val_init_o,
   output logic             det_j_o,
   output logic             det_j_2_o,
   output logic             swap_o,
   output logic             store_temp_o,
   output logic             gen_final_o,
   output logic             end_o,
   output logic             ready_o,
   output logic             busy_o,
   output logic             ks_valid_o,
   output logic [7:0]       ks_byte_o,
   output logic             done_o
);

   localparam logic [7:0] I_LAST = 8'(SARR_DEPTH - 1);

   typedef enum logic [3:0] {
      IDLE, CLEAR, INIT, K_DETJ, K_SWAP, READY,
      P_INC, P_DETJ, P_SWAP, P_TEMP, P_GEN, P_OUT
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       i_q, i_d;
   logic [7:0]       j_q, j_d;
   logic [7:0]       ks_byte_q, ks_byte_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             i_last;
   logic             rem_zero;

   assign i_last   = (i_q == I_LAST);
   assign rem_zero = (rem_q == '0);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         i_q       <= '0;
         j_q       <= '0;
         rem_q     <= '0;
         ks_byte_q <= '0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         rem_q     <= rem_d;
         ks_byte_q <= ks_byte_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      rem_d     = rem_q;
      ks_byte_d = ks_byte_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = CLEAR;
               rem_d   = len_i;
            end
         end
         CLEAR: begin
            i_d     = '0;
            j_d     = '0;
            state_d = INIT;
         end
         INIT: begin
            if (i_last) begin
               i_d     = '0;
               state_d = K_DETJ;
            end else begin
               i_d = i_q + 8'd1;
            end
         end
         K_DETJ: begin
            j_d     = ncounterJ_i;
            state_d = K_SWAP;
         end
         K_SWAP: begin
            if (i_last) begin
               i_d     = '0;
               j_d     = '0;
               state_d = rem_zero ? IDLE : READY;
            end else begin
               i_d     = i_q + 8'd1;
               state_d = K_DETJ;
            end
         end
         READY: begin
            if (ks_req_i) state_d = P_INC;
         end
         P_INC: begin
            i_d     = i_q + 8'd1;
            state_d = P_DETJ;
         end
         P_DETJ: begin
            j_d     = ncounterJ_i;
            state_d = P_SWAP;
         end
         P_SWAP: state_d = P_TEMP;
         P_TEMP: state_d = P_GEN;
         P_GEN: begin
            ks_byte_d = rdata_i;
            rem_d     = rem_q - 1'b1;
            state_d   = P_OUT;
         end
         P_OUT: state_d = rem_zero ? IDLE : READY;
         default: state_d = IDLE;
      endcase
      // abort overrides every transition but keeps the last keystream byte visible
      if (abort_i) begin
         state_d = IDLE;
         i_d     = '0;
         j_d     = '0;
         rem_d   = '0;
      end
   end

   always_comb begin
      clearCounterJ_o = 1'b0;
      val_init_o      = 1'b0;
      det_j_o         = 1'b0;
      det_j_2_o       = 1'b0;
      swap_o          = 1'b0;
      store_temp_o    = 1'b0;
      gen_final_o     = 1'b0;
      end_o           = 1'b0;
      ready_o         = 1'b0;
      ks_valid_o      = 1'b0;
      done_o          = 1'b0;
      case (state_q)
         CLEAR:  clearCounterJ_o = 1'b1;
         INIT:   val_init_o      = 1'b1;
         K_DETJ: det_j_o         = 1'b1;
         K_SWAP: begin
            swap_o          = 1'b1;
            clearCounterJ_o = i_last;
            done_o          = i_last && rem_zero;
         end
         READY:  ready_o      = 1'b1;
         P_DETJ: det_j_2_o    = 1'b1;
         P_SWAP: swap_o       = 1'b1;
         P_TEMP: store_temp_o = 1'b1;
         P_GEN:  gen_final_o  = 1'b1;
         P_OUT: begin
            ks_valid_o = 1'b1;
            end_o      = rem_zero;
            done_o     = rem_zero;
         end
         default: ;
      endcase
   end

   assign busy_o     = (state_q != IDLE);
   assign counterI_o = i_q;
   assign counterJ_o = j_q;
   assign ks_byte_o  = ks_byte_q;

endmodule

// File: tb/tb_rc4_ctrl_fsm.sv
// Directed bench for rc4_ctrl_fsm: a checkpoint table over one full len=2 run, then hand-written
// sequences for reset, len=0, abort and PRGA I wrap-around.
module tb_rc4_ctrl_fsm;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start_i, abort_i, ks_req_i;
   logic [15:0] len_i;
   logic [7:0]  ncounterJ_i, rdata_i;
   logic [7:0]  counterI_o, counterJ_o, ks_byte_o;
   logic        clearCounterJ_o, val_init_o, det_j_o, det_j_2_o, swap_o, store_temp_o;
   logic        gen_final_o, end_o, ready_o, busy_o, ks_valid_o, done_o;

   rc4_ctrl_fsm #(.SARR_DEPTH(256), .LEN_W(16)) dut (
      .clk(clk), .n_rst(n_rst), .start_i(start_i), .abort_i(abort_i), .len_i(len_i),
      .ks_req_i(ks_req_i), .ncounterJ_i(ncounterJ_i), .rdata_i(rdata_i),
      .counterI_o(counterI_o), .counterJ_o(counterJ_o), .clearCounterJ_o(clearCounterJ_o),
      .val_init_o(val_init_o), .det_j_o(det_j_o), .det_j_2_o(det_j_2_o), .swap_o(swap_o),
      .store_temp_o(store_temp_o), .gen_final_o(gen_final_o), .end_o(end_o), .ready_o(ready_o),
      .busy_o(busy_o), .ks_valid_o(ks_valid_o), .ks_byte_o(ks_byte_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   // strobe word: {clr, init, det_j, det_j_2, swap, temp, gen, end, ready, valid, done}
   localparam logic [10:0] NONE = 11'h000, CLR = 11'h400, INI = 11'h200, DJ = 11'h100;
   localparam logic [10:0] DJ2 = 11'h080, SW = 11'h040, TMP = 11'h020, GEN = 11'h010;
   localparam logic [10:0] ENDO = 11'h008, RDY = 11'h004, VAL = 11'h002, DON = 11'h001;

   typedef struct {
      int          cyc;
      logic        req;
      logic        start;
      logic [10:0] strb;
      logic        chk_ij;
      logic [7:0]  i;
      logic [7:0]  j;
      logic        busy;
      logic [7:0]  ks;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc;

   int n_init = 0, n_dj = 0, n_dj2 = 0, n_sw = 0, n_clr = 0, n_done = 0, n_val = 0;
   int n_rdy = 0, n_bad = 0;

   function automatic logic [10:0] strobes();
      return {clearCounterJ_o, val_init_o, det_j_o, det_j_2_o, swap_o, store_temp_o,
              gen_final_o, end_o, ready_o, ks_valid_o, done_o};
   endfunction

   always @(negedge clk) begin
      logic [6:0] s;
      s = {clearCounterJ_o, val_init_o, det_j_o, det_j_2_o, swap_o, store_temp_o, gen_final_o};
      n_init += int'(val_init_o);
      n_dj   += int'(det_j_o);
      n_dj2  += int'(det_j_2_o);
      n_sw   += int'(swap_o);
      n_clr  += int'(clearCounterJ_o);
      n_done += int'(done_o);
      n_val  += int'(ks_valid_o);
      n_rdy  += int'(ready_o);
      if ($countones(s) > 1 && s != 7'b1000100) n_bad++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [15:0] len);
      start_i = 1'b1;
      len_i   = len;
      tick();
      start_i = 1'b0;
      cyc     = 1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) begin
         tick();
         cyc++;
      end
   endtask

   task automatic check_vec(input vec_t v);
      chk($sformatf("c%0d strobes", v.cyc), 32'(strobes()), 32'(v.strb));
      chk($sformatf("c%0d busy", v.cyc), 32'(busy_o), 32'(v.busy));
      chk($sformatf("c%0d ks_byte", v.cyc), 32'(ks_byte_o), 32'(v.ks));
      if (v.chk_ij) begin
         chk($sformatf("c%0d I", v.cyc), 32'(counterI_o), 32'(v.i));
         chk($sformatf("c%0d J", v.cyc), 32'(counterJ_o), 32'(v.j));
      end
   endtask

   function automatic vec_t mk(int c, logic rq, logic st, logic [10:0] sb, logic cij,
                               logic [7:0] i, logic [7:0] j, logic bz, logic [7:0] ks);
      vec_t v;
      v.cyc = c; v.req = rq; v.start = st; v.strb = sb; v.chk_ij = cij;
      v.i = i; v.j = j; v.busy = bz; v.ks = ks;
      return v;
   endfunction

   initial begin
      int s_init, s_dj, s_dj2, s_sw, s_clr, s_done, s_val, s_rdy, s_bad;
      int nbytes;
      bit hit;

      // len=2 run; ncounterJ is 10 in KSA, 0x37 for byte 1, 0x5C for byte 2
      tbl.push_back(mk(1,   0, 0, CLR,       1, 8'd0,   8'd0,   1, 8'h00));
      tbl.push_back(mk(2,   0, 0, INI,       1, 8'd0,   8'd0,   1, 8'h00));
      tbl.push_back(mk(3,   0, 0, INI,       1, 8'd1,   8'd0,   1, 8'h00));
      tbl.push_back(mk(102, 0, 0, INI,       1, 8'd100, 8'd0,   1, 8'h00));
      tbl.push_back(mk(257, 0, 0, INI,       1, 8'd255, 8'd0,   1, 8'h00));
      tbl.push_back(mk(258, 0, 0, DJ,        1, 8'd0,   8'd0,   1, 8'h00));
      tbl.push_back(mk(259, 0, 0, SW,        1, 8'd0,   8'd10,  1, 8'h00));
      tbl.push_back(mk(260, 0, 0, DJ,        1, 8'd1,   8'd10,  1, 8'h00));
      tbl.push_back(mk(400, 0, 1, DJ,        1, 8'd71,  8'd10,  1, 8'h00));
      tbl.push_back(mk(401, 0, 0, SW,        1, 8'd71,  8'd10,  1, 8'h00));
      tbl.push_back(mk(768, 0, 0, DJ,        1, 8'd255, 8'd10,  1, 8'h00));
      tbl.push_back(mk(769, 0, 0, SW | CLR,  1, 8'd255, 8'd10,  1, 8'h00));
      tbl.push_back(mk(770, 1, 0, RDY,       1, 8'd0,   8'd0,   1, 8'h00));
      tbl.push_back(mk(771, 0, 0, NONE,      1, 8'd0,   8'd0,   1, 8'h00));
      tbl.push_back(mk(772, 0, 0, DJ2,       1, 8'd1,   8'd0,   1, 8'h00));
      tbl.push_back(mk(773, 1, 0, SW,        1, 8'd1,   8'h37,  1, 8'h00));
      tbl.push_back(mk(774, 0, 0, TMP,       1, 8'd1,   8'h37,  1, 8'h00));
      tbl.push_back(mk(775, 0, 0, GEN,       1, 8'd1,   8'h37,  1, 8'h00));
      tbl.push_back(mk(776, 0, 0, VAL,       1, 8'd1,   8'h37,  1, 8'hA5));
      tbl.push_back(mk(777, 0, 0, RDY,       1, 8'd1,   8'h37,  1, 8'hA5));
      tbl.push_back(mk(778, 1, 0, RDY,       1, 8'd1,   8'h37,  1, 8'hA5));
      tbl.push_back(mk(779, 0, 0, NONE,      1, 8'd1,   8'h37,  1, 8'hA5));
      tbl.push_back(mk(780, 0, 0, DJ2,       1, 8'd2,   8'h37,  1, 8'hA5));
      tbl.push_back(mk(781, 0, 0, SW,        1, 8'd2,   8'h5C,  1, 8'hA5));
      tbl.push_back(mk(783, 0, 0, GEN,       1, 8'd2,   8'h5C,  1, 8'hA5));
      tbl.push_back(mk(784, 0, 0, VAL | ENDO | DON, 1, 8'd2, 8'h5C, 1, 8'h3C));
      tbl.push_back(mk(785, 0, 0, NONE,      0, 8'd0,   8'd0,   0, 8'h3C));
      tbl.push_back(mk(786, 0, 0, NONE,      0, 8'd0,   8'd0,   0, 8'h3C));

      n_rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; ks_req_i = 1'b0;
      len_i = '0; ncounterJ_i = 8'd10; rdata_i = 8'hA5;
      tick(); tick();
      chk("reset strobes", 32'(strobes()), 32'(NONE));
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset I", 32'(counterI_o), 32'd0);
      chk("reset J", 32'(counterJ_o), 32'd0);
      chk("reset ks_byte", 32'(ks_byte_o), 32'd0);
      n_rst = 1'b1;
      tick();

      // table-driven full run
      do_start(16'd2);
      s_init = n_init; s_dj = n_dj; s_dj2 = n_dj2; s_sw = n_sw; s_clr = n_clr;
      s_done = n_done; s_val = n_val; s_rdy = n_rdy; s_bad = n_bad;
      foreach (tbl[k]) begin
         while (cyc < tbl[k].cyc) begin
            ncounterJ_i = (cyc < 770) ? 8'd10 : (cyc < 778) ? 8'h37 : 8'h5C;
            rdata_i     = (cyc >= 778) ? 8'h3C : 8'hA5;
            tick();
            cyc++;
            ks_req_i = 1'b0;
            start_i  = 1'b0;
         end
         check_vec(tbl[k]);
         ks_req_i = tbl[k].req;
         start_i  = tbl[k].start;
      end
      ks_req_i = 1'b0; start_i = 1'b0;
      chk("run init count", 32'(n_init - s_init), 32'd256);
      chk("run det_j count", 32'(n_dj - s_dj), 32'd256);
      chk("run det_j_2 count", 32'(n_dj2 - s_dj2), 32'd2);
      chk("run swap count", 32'(n_sw - s_sw), 32'd258);
      chk("run clear count", 32'(n_clr - s_clr), 32'd2);
      chk("run done count", 32'(n_done - s_done), 32'd1);
      chk("run valid count", 32'(n_val - s_val), 32'd2);
      chk("run ready count", 32'(n_rdy - s_rdy), 32'd3);
      chk("run multi-hot strobes", 32'(n_bad - s_bad), 32'd0);

      // reset mid-INIT
      ncounterJ_i = 8'd10;
      do_start(16'd4);
      run_to(102);
      chk("mid-init I", 32'(counterI_o), 32'd100);
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      chk("mid-reset strobes", 32'(strobes()), 32'(NONE));
      chk("mid-reset busy", 32'(busy_o), 32'd0);
      chk("mid-reset I", 32'(counterI_o), 32'd0);
      chk("mid-reset J", 32'(counterJ_o), 32'd0);
      chk("mid-reset ks_byte", 32'(ks_byte_o), 32'd0);
      tick();

      // len=0: schedule only, done on the last K_SWAP, never READY
      do_start(16'd0);
      s_rdy = n_rdy;
      run_to(769);
      chk("len0 last swap strobes", 32'(strobes()), 32'(SW | CLR | DON));
      run_to(770);
      chk("len0 after strobes", 32'(strobes()), 32'(NONE));
      chk("len0 after busy", 32'(busy_o), 32'd0);
      run_to(775);
      chk("len0 ready count", 32'(n_rdy - s_rdy), 32'd0);

      // abort in P_SWAP of the second byte; first byte is kept
      rdata_i = 8'h5A;
      do_start(16'd3);
      run_to(770);
      chk("abort run ready", 32'(ready_o), 32'd1);
      ks_req_i = 1'b1;
      run_to(771);
      ks_req_i = 1'b0;
      run_to(776);
      chk("abort run byte1 valid", 32'(ks_valid_o), 32'd1);
      chk("abort run byte1", 32'(ks_byte_o), 32'h5A);
      rdata_i = 8'hEE;
      ks_req_i = 1'b1;
      run_to(778);
      ks_req_i = 1'b0;
      run_to(780);
      chk("abort run in P_SWAP", 32'(strobes()), 32'(SW));
      s_done = n_done;
      abort_i = 1'b1;
      run_to(781);
      abort_i = 1'b0;
      chk("abort strobes", 32'(strobes()), 32'(NONE));
      chk("abort busy", 32'(busy_o), 32'd0);
      chk("abort I", 32'(counterI_o), 32'd0);
      chk("abort J", 32'(counterJ_o), 32'd0);
      chk("abort ks_byte kept", 32'(ks_byte_o), 32'h5A);
      run_to(785);
      chk("abort no done", 32'(n_done - s_done), 32'd0);
      chk("abort stays idle", 32'(busy_o), 32'd0);

      // abort together with start in IDLE
      start_i = 1'b1; abort_i = 1'b1; len_i = 16'd5;
      tick();
      start_i = 1'b0; abort_i = 1'b0;
      chk("abort+start busy", 32'(busy_o), 32'd0);
      tick();
      chk("abort+start busy later", 32'(busy_o), 32'd0);

      // PRGA I wraps 255 -> 0 on the 256th byte; ks_req held high
      do_start(16'd300);
      s_done = n_done;
      ks_req_i = 1'b1;
      nbytes = 0;
      hit = 1'b0;
      for (int t = 0; t < 3000 && !hit; t++) begin
         tick();
         if (ks_valid_o) begin
            nbytes++;
            if (nbytes == 255) chk("wrap I at byte 255", 32'(counterI_o), 32'd255);
            if (nbytes == 256) begin
               chk("wrap I at byte 256", 32'(counterI_o), 32'd0);
               chk("wrap end_o", 32'(end_o), 32'd0);
               hit = 1'b1;
            end
         end
      end
      ks_req_i = 1'b0;
      chk("wrap reached byte 256", 32'(hit), 32'd1);
      chk("wrap no done", 32'(n_done - s_done), 32'd0);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("wrap abort busy", 32'(busy_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
